// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared types and constants for the RV32I core's data-memory path.
//   op_dmem_size : access size encoding produced by the core (byte/half/word)
//   lsu_state_e  : load/store unit sequencing states
//   LSU_BE_*     : byte-enable masks for a right-aligned access of each size
//   lsu_size_mask / lsu_misaligned : helpers shared by the LSU and its aligner
// -----------------------------------------------------------------------------
package risc_pkg;

    typedef enum logic [1:0] {
        DMEM_BYTE = 2'd0,
        DMEM_HALF = 2'd1,
        DMEM_WORD = 2'd2
    } op_dmem_size;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ0  = 3'd1,
        LSU_WAIT0 = 3'd2,
        LSU_REQ1  = 3'd3,
        LSU_WAIT1 = 3'd4,
        LSU_DONE  = 3'd5,
        LSU_ERR   = 3'd6
    } lsu_state_e;

    localparam logic [3:0] LSU_BE_BYTE = 4'b0001;
    localparam logic [3:0] LSU_BE_HALF = 4'b0011;
    localparam logic [3:0] LSU_BE_WORD = 4'b1111;

    // The unused size encoding (3) behaves like a word so the unit never hangs.
    function automatic logic [3:0] lsu_size_mask(input logic [1:0] size);
        case (size)
            DMEM_BYTE: return LSU_BE_BYTE;
            DMEM_HALF: return LSU_BE_HALF;
            default:   return LSU_BE_WORD;
        endcase
    endfunction

    // An access is misaligned when it does not fit inside one bus word.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            DMEM_BYTE: return 1'b0;
            DMEM_HALF: return (off == 2'd3);
            default:   return (off != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the load/store unit.
//   off, size, zero_ex : byte offset within the word, access size, load extension
//   wdata              : right-aligned store data from the core
//   rdata0 / rdata1    : raw bus words returned by beat 0 / beat 1
//   be0 / be1          : byte enables for beat 0 / beat 1 (be1 is 0 if unsplit)
//   wdata0 / wdata1    : lane-aligned store data for beat 0 / beat 1
//   rdata              : right-aligned, extended load result
// -----------------------------------------------------------------------------
module lsu_align
    import risc_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        zero_ex,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata
);

    logic [3:0]  mask;
    logic [4:0]  sh;
    logic [5:0]  sh_inv;
    logic [2:0]  off_inv;
    logic [31:0] raw;

    // Shifts by a full width (off == 0 on the beat-1 side) yield zero, which is
    // exactly the "no second beat" value, so one formula covers both cases.
    always_comb begin
        mask    = lsu_size_mask(size);
        sh      = {off, 3'b000};
        sh_inv  = 6'd32 - {1'b0, sh};
        off_inv = 3'd4 - {1'b0, off};

        be0     = mask << off;
        be1     = mask >> off_inv;
        wdata0  = wdata << sh;
        wdata1  = wdata >> sh_inv;

        raw     = (rdata0 >> sh) | (rdata1 << sh_inv);

        case (size)
            DMEM_BYTE: rdata = zero_ex ? {24'h000000, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            DMEM_HALF: rdata = zero_ex ? {16'h0000,   raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default:   rdata = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle bridge between the execute stage and a handshaked, word-wide,
// little-endian data bus. One access at a time, at most one outstanding beat.
//   clk, res        : clock (rising edge), asynchronous active-high reset
//   core_*          : request (held until done), store/load, address, size,
//                     extension, store data; busy/done/err/rdata back to core
//   bus_req/bus_gnt : beat request, accepted on the edge where both are high
//   bus_we/addr/be/wdata : registered beat attributes, stable until granted
//   bus_rvalid/rdata: read data return, at least one cycle after the grant
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into
// two beats; without it a misaligned access reports core_err with no bus beat.
// -----------------------------------------------------------------------------
module load_store_unit
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  core_req,
    input  logic                  core_wr,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [1:0]            core_size,
    input  logic                  core_zero_ex,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_busy,
    output logic                  core_done,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_err,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  wr_q, wr_d;
    logic                  zero_ex_q, zero_ex_d;
    logic                  split_q, split_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           data0_q, data0_d;
    logic [31:0]           data1_q, data1_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [31:0]           bus_wdata_q, bus_wdata_d;

    logic                  in_idle;
    logic [1:0]            al_off, al_size;
    logic [31:0]           al_wdata;
    logic [3:0]            al_be0, al_be1;
    logic [31:0]           al_wdata0, al_wdata1, al_rdata;
    logic                  misaligned_in, split_in, err_in;
    logic [ADDR_WIDTH-1:0] word_addr_in, beat1_addr;
    logic                  drop_bus;

    // In IDLE the aligner sees the incoming request so beat 0 can be registered
    // on the acceptance edge; afterwards it works from the latched request.
    assign in_idle  = (state_q == LSU_IDLE);
    assign al_off   = in_idle ? core_addr[1:0] : off_q;
    assign al_size  = in_idle ? core_size      : size_q;
    assign al_wdata = in_idle ? core_wdata     : wdata_q;

    lsu_align u_align (
        .off     (al_off),
        .size    (al_size),
        .zero_ex (zero_ex_q),
        .wdata   (al_wdata),
        .rdata0  (data0_q),
        .rdata1  (data1_q),
        .be0     (al_be0),
        .be1     (al_be1),
        .wdata0  (al_wdata0),
        .wdata1  (al_wdata1),
        .rdata   (al_rdata)
    );

    assign misaligned_in = lsu_misaligned(core_size, core_addr[1:0]);
`ifdef LSU_MISALIGN_SPLIT_EN
    assign split_in = misaligned_in;
    assign err_in   = 1'b0;
`else
    assign split_in = 1'b0;
    assign err_in   = misaligned_in;
`endif

    // Beat 1 wraps modulo the address width at the top of memory.
    assign word_addr_in = {core_addr[ADDR_WIDTH-1:2], 2'b00};
    assign beat1_addr   = addr_q + ADDR_WIDTH'(4);

    // Next-state and beat sequencing. drop_bus clears the registered beat once
    // the last request phase has been granted so the bus idles at zero.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        off_d       = off_q;
        size_d      = size_q;
        wr_d        = wr_q;
        zero_ex_d   = zero_ex_q;
        split_d     = split_q;
        wdata_d     = wdata_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        drop_bus    = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (core_req) begin
                    addr_d    = word_addr_in;
                    off_d     = core_addr[1:0];
                    size_d    = core_size;
                    wr_d      = core_wr;
                    zero_ex_d = core_zero_ex;
                    split_d   = split_in;
                    wdata_d   = core_wdata;
                    data0_d   = '0;
                    data1_d   = '0;
                    if (err_in) begin
                        state_d = LSU_ERR;
                    end else begin
                        state_d     = LSU_REQ0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = core_wr;
                        bus_addr_d  = word_addr_in;
                        bus_be_d    = al_be0;
                        bus_wdata_d = core_wr ? al_wdata0 : '0;
                    end
                end
            end
            LSU_REQ0: begin
                if (bus_gnt) begin
                    if (wr_q && split_q) begin
                        state_d     = LSU_REQ1;
                        bus_addr_d  = beat1_addr;
                        bus_be_d    = al_be1;
                        bus_wdata_d = al_wdata1;
                    end else begin
                        state_d  = wr_q ? LSU_DONE : LSU_WAIT0;
                        drop_bus = 1'b1;
                    end
                end
            end
            LSU_WAIT0: begin
                if (bus_rvalid) begin
                    data0_d = bus_rdata;
                    if (split_q) begin
                        state_d     = LSU_REQ1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = beat1_addr;
                        bus_be_d    = al_be1;
                        bus_wdata_d = '0;
                    end else begin
                        state_d = LSU_DONE;
                    end
                end
            end
            LSU_REQ1: begin
                if (bus_gnt) begin
                    state_d  = wr_q ? LSU_DONE : LSU_WAIT1;
                    drop_bus = 1'b1;
                end
            end
            LSU_WAIT1: begin
                if (bus_rvalid) begin
                    data1_d = bus_rdata;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            LSU_ERR:  state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase

        if (drop_bus) begin
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_addr_d  = '0;
            bus_be_d    = '0;
            bus_wdata_d = '0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= LSU_IDLE;
            addr_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            wr_q        <= 1'b0;
            zero_ex_q   <= 1'b0;
            split_q     <= 1'b0;
            wdata_q     <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            wr_q        <= wr_d;
            zero_ex_q   <= zero_ex_d;
            split_q     <= split_d;
            wdata_q     <= wdata_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign core_done  = (state_q == LSU_DONE);
    assign core_err   = (state_q == LSU_ERR);
    assign core_rdata = core_done ? al_rdata : '0;
    assign core_busy  = core_req & ~core_done;

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory interface between the RV32I core's execute stage and a handshaked, word-wide, little-endian data bus.
- Core side accepts one load/store, using the size and zero-extend encoding the core already produces. The unit stalls the core until the access completes.
- Bus side performs at most one outstanding transaction. It aligns bytes into lanes, generates byte enables, and sign/zero-extends load data.
- Replaces the core's direct asynchronous RAM hookup so slower memories can be attached.

Parameters:
ADDR_WIDTH, 16, byte-address width on both core and bus sides.
DATA_WIDTH, 32, bus data width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge.
res  in  1  asynchronous, active-high reset.
core_req  in  1  access request; held high by the core until core_done.
core_wr  in  1  1 = store, 0 = load.
core_addr  in  ADDR_WIDTH  byte address.
core_size  in  2  op_dmem_size: byte = 0, half = 1, word = 2.
core_zero_ex  in  1  loads: 1 = zero-extend, 0 = sign-extend.
core_wdata  in  32  store data, right-aligned.
core_busy  out  1  stall to the core; combinational, equals core_req & ~core_done.
core_done  out  1  one-cycle pulse when the access completes.
core_rdata  out  32  extended load data; valid while core_done is high, 0 otherwise.
core_err  out  1  one-cycle misalignment error pulse, reported instead of core_done.
bus_req  out  1  bus request.
bus_gnt  in  1  grant; the beat is accepted at the rising edge where bus_req & bus_gnt.
bus_we  out  1  write enable.
bus_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
bus_be  out  4  byte enables; bit i enables byte lane i (bits 8i+7 down to 8i).
bus_wdata  out  32  lane-aligned write data.
bus_rvalid  in  1  read data valid; arrives no earlier than the cycle after the read grant.
bus_rdata  in  32  read data.

Behaviour:
- Reset (asynchronous, any state): state = IDLE. bus_req, bus_we, core_done, core_err = 0; bus_addr, bus_be, bus_wdata, core_rdata = 0; internal latches cleared. An in-flight beat is abandoned, and any later bus_rvalid is ignored in IDLE.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, ERR.
- IDLE:
  - When core_req is high, latch addr, wr, size, zero_ex and wdata.
  - If the access is misaligned, go to REQ1-path splitting (see below) or ERR; otherwise go to REQ0.
  - Misaligned means: word with off != 0, or half with off == 3, where off = addr[1:0].
- REQ0 / REQ1: bus_req = 1. bus_addr, bus_we, bus_be and bus_wdata are registered and stay stable until granted.
  - On grant, a write goes to the next beat or DONE.
  - On grant, a read goes to WAIT0 or WAIT1.
- WAIT0 / WAIT1: bus_req = 0. On bus_rvalid, capture bus_rdata, then go to the next beat or DONE.
- DONE: core_done = 1 for one cycle, then IDLE. core_req is ignored in DONE; the next request is accepted in IDLE.
- ERR: core_err = 1 for one cycle with no bus activity, then IDLE.
- Byte enables for an unsplit access: byte = 0001 << off; half = 0011 << off; word = 1111.
- Write data: bus_wdata = core_wdata << 8*off; bits shifted past bit 31 are discarded.
- Read data: raw = beat0_data >> 8*off. Result is byte raw[7:0] or half raw[15:0], extended per zero_ex; word passes through.
- Minimum latency, aligned access with bus_gnt already high:
  - Store: core_done 2 cycles after the core_req acceptance edge.
  - Load with rvalid in the cycle after grant: core_done 3 cycles after acceptance.
- Address arithmetic is modulo 2^ADDR_WIDTH; beat 1 at the top word wraps to address 0.
- bus_gnt or bus_rvalid arriving in a state that does not expect it is ignored.

Optional Feature:
LSU_MISALIGN_SPLIT_EN
- Defined: a misaligned access is split into two beats.
  - Beat 0 at {addr[A-1:2], 00} with be0 = (full mask << off)[3:0].
  - Beat 1 at beat-0 address + 4 with be1 = full mask >> (4 - off).
  - Store data: beat-1 wdata = core_wdata >> 8*(4 - off).
  - Load data: raw = (d0 >> 8*off) | (d1 << 8*(4 - off)).
  - core_done is asserted after beat 1 completes.
- Undefined: misaligned access goes IDLE -> ERR, with no bus_req.

Decomposition:
- risc_pkg:
  - op_dmem_size, with explicit encodings.
  - new lsu_state_e enum.
  - constants LSU_BE_BYTE = 4'b0001, LSU_BE_HALF = 4'b0011, LSU_BE_WORD = 4'b1111.
- Sub-module lsu_align: combinational. Computes the be/wdata lane shifts and load-data assembly/extension. It is unit-testable on its own; the FSM stays in load_store_unit.

Test Plan:
- Reset mid-op: res asserted in WAIT0 -> all outputs 0 immediately. A late bus_rvalid does not produce core_done; the next request starts cleanly.
- Store byte, addr 0x0003, wdata 0x000000A5, gnt tied high -> bus_addr 0x0000, be 1000, wdata 0xA5000000, core_done 2 cycles after acceptance.
- Load half signed, addr 0x0002, bus_rdata 0x80120000 -> core_rdata 0xFFFF8012. Same access with zero_ex = 1 -> 0x00008012.
- Backpressure: gnt low for 5 cycles on a word store -> bus_req, bus_addr and bus_wdata are held stable; core_busy stays high; exactly one beat is accepted.
- Misaligned word load, addr 0x0005, beats return 0x44332211 and 0x88776655.
  - Split enabled: beats at 0x0004 (be 1110) and 0x0008 (be 0001); core_rdata 0x55443322.
  - Split disabled: core_err pulse, no bus_req.
- Wrap, split enabled: word store at 0xFFFE -> beats at 0xFFFC (be 1100) and 0x0000 (be 0011).
